pp_pipeline_accel_mat2axis_pack: RTL and testbench
==================================================

# pp_pipeline_accel_mat2axis_pack

Output packer for the preprocessing accelerator: drains the 8-pixel-per-clock image FIFO of the final pipeline stage and emits an AXI4-Stream video frame. Runs once per frame under ap_ctrl_chain control. Consumes the constant last-block pixel width produced by the last-block-width stage to build TKEEP on the final beat of every row. Generates TUSER start-of-frame and TLAST end-of-frame.

## Interface
Parameters:
- NPPC, 8, pixels per beat
- PXL_W, 8, bits per pixel; DATA_W = NPPC*PXL_W = 64

Ports:
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst_n  in  1  reset; asynchronous and active-low
- ap_start  in  1  start request
- ap_ready  out  1  arguments sampled this cycle
- ap_done  out  1  frame complete; held until ap_continue
- ap_continue  in  1  acknowledges ap_done
- ap_idle  out  1  block idle
- rows  in  16  frame height in rows, sampled on start
- cols  in  16  frame width in pixels, sampled on start
- last_blk_pxl_width  in  4  valid pixels in last beat of each row, sampled on start
- in_dout  in  64  FIFO read data; pixel k at bits [8k+7:8k]
- in_empty_n  in  1  FIFO not empty
- in_read  out  1  FIFO pop
- m_axis_tdata  out  64  output data
- m_axis_tkeep  out  8  byte enables
- m_axis_tuser  out  1  first beat of frame
- m_axis_tlast  out  1  last beat of frame
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on ap_start=1 and done_reg=0: latch rows, cols, width; beats_per_row = (cols+7)>>3 (17-bit add); ap_ready=1 this cycle; go RUN. If rows=0 or cols=0, go DONE directly; no beats emitted.
- width normalisation: 0 or >8 → 8; 1..8 used as-is. Not cross-checked against cols.
- RUN: in_read = in_empty_n & (~m_axis_tvalid | m_axis_tready). Each pop loads output register: tdata=in_dout; tkeep = 8'hFF, except last beat of a row = (1<<width)-1; tuser=1 on beat (0,0) only; tlast=1 on final beat of final row only.
- Counters: col_cnt 0..beats_per_row-1, wraps to 0 and increments row_cnt; on pop of final beat → FLUSH, in_read forced 0.
- FLUSH: wait for tvalid&tready of the held last beat → DONE.
- DONE: ap_done=1; done_reg set; on ap_continue=1 clear done_reg and go IDLE (same cycle continue → IDLE next cycle).
- ap_idle = (state==IDLE) & ~ap_start.
- Output register holds data/sideband stable while tvalid=1 & tready=0 (AXIS rule). tvalid never deasserts without handshake.

## Timing
- Reset values: ap_done, ap_ready, ap_idle(registered portion), in_read, m_axis_tvalid, tuser, tlast = 0; tkeep=0; tdata=0; state=IDLE; counters 0. ap_idle=1 combinationally after reset when ap_start=0.
- Start to first in_read: 1 cycle (RUN entered the cycle after ap_ready).
- in_read to tvalid: 1 cycle. Sustained 1 beat/cycle with tready=1 and FIFO non-empty.
- Pop and output handshake in same cycle allowed (register reloads).
- Last handshake to ap_done: 1 cycle.
- Reset asserted mid-frame: immediate return to IDLE, tvalid drops, partial frame abandoned; no recovery of FIFO contents.
- beats_per_row=1: each beat is both first and last of its row; tkeep from width.

## Structure
- Shared package pp_pipeline_accel_pkg: NPPC, PXL_W, DATA_W, state enum, width-to-tkeep function.
- Optional sub-module pp_pipeline_accel_axis_out_reg: single-entry AXIS output register (data+keep+user+last).

## Test plan
- rows=2, cols=20, width=4, tready=1, FIFO full → 6 beats; tkeep FF,FF,0F,FF,FF,0F; tuser on beat 0; tlast on beat 5; ap_done 1 cycle after beat 5.
- rows=1, cols=16, width=0 → 2 beats, both tkeep=FF, tlast on beat 1.
- rows=3, cols=64, tready toggling 1/0 every cycle, FIFO gaps → 24 beats, no data loss or reorder, data stable while stalled.
- rows=0, cols=100 → no in_read, no tvalid; ap_done 1 cycle after ap_ready; held until ap_continue pulse.
- ap_continue held 0 after done, second ap_start → ap_ready stays 0 until continue; then new frame starts.
- Assert ap_rst_n low mid-row 1 → all outputs at reset values asynchronously; fresh frame after release completes correctly.

Source files
------------

// File: rtl/pp_pipeline_accel_pkg.sv
// pp_pipeline_accel_pkg: shared constants, state encoding and TKEEP helper for the output packer
package pp_pipeline_accel_pkg;
  localparam int NPPC = 8;
  localparam int PXL_W = 8;
  localparam int DATA_W = NPPC * PXL_W;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  function automatic logic [NPPC-1:0] width_keep(input logic [3:0] w);
    return (w == 4'd0 || w > 4'd8) ? 8'hFF : ~(8'hFF << w);
  endfunction
endpackage

// File: rtl/pp_pipeline_accel_mat2axis_pack_if.sv
// pp_pipeline_accel_mat2axis_pack_if: AXI4-Stream video bus with TKEEP/TUSER/TLAST
interface pp_pipeline_accel_mat2axis_pack_if;
  import pp_pipeline_accel_pkg::*;
  logic [DATA_W-1:0] tdata;
  logic [NPPC-1:0] tkeep;
  logic tuser;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pp_pipeline_accel_axis_out_reg.sv
// pp_pipeline_accel_axis_out_reg: single-entry AXIS output register, holds a beat until accepted
module pp_pipeline_accel_axis_out_reg
  import pp_pipeline_accel_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic load,
  input  logic [DATA_W-1:0] data,
  input  logic [NPPC-1:0] keep,
  input  logic user,
  input  logic last,
  pp_pipeline_accel_mat2axis_pack_if.master m_axis
);
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      m_axis.tkeep <= '0;
      m_axis.tuser <= 1'b0;
      m_axis.tlast <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata <= data;
      m_axis.tkeep <= keep;
      m_axis.tuser <= user;
      m_axis.tlast <= last;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
endmodule

// File: rtl/pp_pipeline_accel_mat2axis_pack.sv
// pp_pipeline_accel_mat2axis_pack: drains the 8-pixel FIFO into one AXI4-Stream frame per ap_start
module pp_pipeline_accel_mat2axis_pack
  import pp_pipeline_accel_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic ap_start,
  output logic ap_ready,
  output logic ap_done,
  input  logic ap_continue,
  output logic ap_idle,
  input  logic [15:0] rows,
  input  logic [15:0] cols,
  input  logic [3:0] last_blk_pxl_width,
  input  logic [DATA_W-1:0] in_dout,
  input  logic in_empty_n,
  output logic in_read,
  pp_pipeline_accel_mat2axis_pack_if.master m_axis
);
  state_t state, nstate;
  logic [15:0] rows_q, row_cnt;
  logic [13:0] bpr, col_cnt;
  logic [NPPC-1:0] keep_last;
  logic last_col, last_row, pop;
  always_comb begin
    last_col = col_cnt == bpr - 14'd1;
    last_row = row_cnt == rows_q - 16'd1;
    pop = state == RUN && in_empty_n && (!m_axis.tvalid || m_axis.tready);
    in_read = pop;
    ap_ready = state == IDLE && ap_start;
    ap_done = state == DONE;
    ap_idle = state == IDLE && !ap_start;
    nstate = state;
    case (state)
      IDLE: if (ap_start) nstate = (rows == 16'd0 || cols == 16'd0) ? DONE : RUN;
      RUN: if (pop && last_col && last_row) nstate = FLUSH;
      FLUSH: if (m_axis.tvalid && m_axis.tready) nstate = DONE;
      DONE: if (ap_continue) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= IDLE;
      rows_q <= '0;
      bpr <= '0;
      keep_last <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state <= nstate;
      if (ap_ready) begin
        rows_q <= rows;
        bpr <= 14'(({1'b0, cols} + 17'd7) >> 3);
        keep_last <= width_keep(last_blk_pxl_width);
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (pop) begin
        col_cnt <= last_col ? '0 : col_cnt + 14'd1;
        row_cnt <= row_cnt + {15'd0, last_col};
      end
    end
  pp_pipeline_accel_axis_out_reg u_out (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .load(pop),
    .data(in_dout),
    .keep(last_col ? keep_last : 8'hFF),
    .user(col_cnt == 14'd0 && row_cnt == 16'd0),
    .last(last_col && last_row),
    .m_axis(m_axis)
  );
endmodule

// File: tb/tb_pp_pipeline_accel_mat2axis_pack.sv
// tb_pp_pipeline_accel_mat2axis_pack: frame table plus scoreboard of expected AXIS beats
module tb_pp_pipeline_accel_mat2axis_pack;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0] k;
    logic u;
    logic l;
  } beat_t;
  typedef struct {
    logic [15:0] r;
    logic [15:0] c;
    logic [3:0] w;
    int mode;
    bit gap;
    logic [7:0] lk;
    int beats;
  } vec_t;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, ap_continue = 1'b0;
  logic ap_ready, ap_done, ap_idle, in_read, in_empty_n;
  logic [15:0] rows = '0, cols = '0;
  logic [3:0] width = '0;
  logic [63:0] in_dout;
  pp_pipeline_accel_mat2axis_pack_if m_axis();

  pp_pipeline_accel_mat2axis_pack dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .ap_idle(ap_idle), .rows(rows),
    .cols(cols), .last_blk_pxl_width(width), .in_dout(in_dout), .in_empty_n(in_empty_n),
    .in_read(in_read), .m_axis(m_axis)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0, bad = 0, cyc = 0;
  int mode = 0, first_rd = -1, last_hs = 0, ready_cyc = 0, hs_cnt = 0, rd_cnt = 0, tv_cnt = 0;
  bit gap_en = 0, rd_s = 0, tg = 0, prev_stall = 0;
  beat_t prev_beat, cur, e;
  logic [63:0] fifo_q[$];
  beat_t exp_q[$];
  vec_t tbl[7];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // FIFO model and tready driver: inputs change only 1ns after the rising edge
  always @(posedge ap_clk) begin
    cyc++;
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    rd_s = 0;
    in_dout = fifo_q.size() > 0 ? fifo_q[0] : 64'd0;
    in_empty_n = fifo_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0);
    tg = ~tg;
    m_axis.tready = mode == 0 ? 1'b1 : mode == 1 ? tg : 1'($urandom_range(0, 1));
  end

  always @(negedge ap_clk) begin
    rd_s = in_read;
    if (in_read) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_axis.tvalid) tv_cnt++;
    cur = '{m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast};
    if (prev_stall) begin
      chk("stall_valid", 80'(m_axis.tvalid), 80'd1);
      chk("stall_hold", 80'(cur), 80'(prev_beat));
    end
    prev_stall = m_axis.tvalid && !m_axis.tready;
    prev_beat = cur;
    if (m_axis.tvalid && m_axis.tready) begin
      hs_cnt++;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got %h expected no beat", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 80'(cur), 80'(e));
      end
    end
  end

  task automatic load(input vec_t v);
    int bpr;
    logic [63:0] d;
    bpr = (int'(v.c) + 7) / 8;
    fifo_q.delete();
    exp_q.delete();
    for (int r = 0; r < int'(v.r); r++)
      for (int c = 0; c < bpr; c++) begin
        d = {$urandom, $urandom};
        fifo_q.push_back(d);
        exp_q.push_back('{d, c == bpr - 1 ? v.lk : 8'hFF, r == 0 && c == 0,
                          r == int'(v.r) - 1 && c == bpr - 1});
      end
    mode = v.mode;
    gap_en = v.gap;
    first_rd = -1;
    hs_cnt = 0;
    rd_cnt = 0;
    tv_cnt = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge ap_clk);
    while (!ap_ready && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    chk("ready", 80'(ap_ready), 80'd1);
    ready_cyc = cyc;
    @(posedge ap_clk);
    #2 ap_start = 1'b0;
  endtask

  task automatic finish_frame(input vec_t v, input bit hold);
    int n = 0;
    while (!ap_done && n < 3000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("done_seen", 80'(ap_done), 80'd1);
    chk("done_lat", 80'(cyc), 80'(v.beats > 0 ? last_hs + 1 : ready_cyc + 1));
    chk("beat_count", 80'(hs_cnt), 80'(v.beats));
    chk("sb_empty", 80'(exp_q.size()), 80'd0);
    if (v.beats == 0) begin
      chk("zero_rd", 80'(rd_cnt), 80'd0);
      chk("zero_tvalid", 80'(tv_cnt), 80'd0);
    end
    if (v.beats > 0 && !v.gap) chk("first_rd", 80'(first_rd), 80'(ready_cyc + 1));
    if (v.beats > 0 && !v.gap && v.mode == 0) chk("throughput", 80'(last_hs), 80'(ready_cyc + 1 + v.beats));
    repeat (2) begin
      @(negedge ap_clk);
      chk("done_held", 80'(ap_done), 80'd1);
    end
    if (!hold) begin
      @(posedge ap_clk);
      #2 ap_continue = 1'b1;
      @(posedge ap_clk);
      #2 ap_continue = 1'b0;
      @(negedge ap_clk);
      chk("idle_after", 80'(ap_idle), 80'd1);
      chk("done_clr", 80'(ap_done), 80'd0);
    end
  endtask

  task automatic start(input vec_t v);
    load(v);
    @(posedge ap_clk);
    #2;
    rows = v.r;
    cols = v.c;
    width = v.w;
    ap_start = 1'b1;
    wait_ready();
  endtask

  task automatic run_frame(input vec_t v);
    start(v);
    finish_frame(v, 0);
  endtask

  initial begin
    vec_t rv;
    int n;
    tbl[0] = '{16'd2, 16'd20, 4'd4, 0, 1'b0, 8'h0F, 6};
    tbl[1] = '{16'd1, 16'd16, 4'd0, 0, 1'b0, 8'hFF, 2};
    tbl[2] = '{16'd3, 16'd64, 4'd8, 1, 1'b1, 8'hFF, 24};
    tbl[3] = '{16'd0, 16'd100, 4'd4, 0, 1'b0, 8'h0F, 0};
    tbl[4] = '{16'd2, 16'd8, 4'd3, 0, 1'b0, 8'h07, 2};
    tbl[5] = '{16'd1, 16'd9, 4'd9, 2, 1'b0, 8'hFF, 2};
    tbl[6] = '{16'd4, 16'd40, 4'd5, 2, 1'b1, 8'h1F, 20};
    repeat (3) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_tvalid", 80'(m_axis.tvalid), 80'd0);
    chk("rst_tkeep", 80'(m_axis.tkeep), 80'd0);
    chk("rst_idle", 80'(ap_idle), 80'd1);
    chk("rst_done", 80'(ap_done), 80'd0);
    chk("rst_read", 80'(in_read), 80'd0);
    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // done held without continue: a new start must wait
    start(tbl[0]);
    finish_frame(tbl[0], 1);
    @(posedge ap_clk);
    #2;
    rows = tbl[1].r;
    cols = tbl[1].c;
    width = tbl[1].w;
    ap_start = 1'b1;
    repeat (4) begin
      @(negedge ap_clk);
      chk("blocked_ready", 80'(ap_ready), 80'd0);
      chk("blocked_done", 80'(ap_done), 80'd1);
    end
    load(tbl[1]);
    @(posedge ap_clk);
    #2 ap_continue = 1'b1;
    @(posedge ap_clk);
    #2 ap_continue = 1'b0;
    wait_ready();
    finish_frame(tbl[1], 0);

    // reset in the middle of row 1, then a fresh frame
    rv = '{16'd3, 16'd64, 4'd8, 0, 1'b0, 8'hFF, 24};
    start(rv);
    n = 0;
    while (hs_cnt < 10 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("pre_rst_beats", 80'(hs_cnt >= 10), 80'd1);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    prev_stall = 0;
    #1;
    chk("arst_tvalid", 80'(m_axis.tvalid), 80'd0);
    chk("arst_tdata", 80'(m_axis.tdata), 80'd0);
    chk("arst_side", 80'({m_axis.tkeep, m_axis.tuser, m_axis.tlast}), 80'd0);
    chk("arst_read", 80'(in_read), 80'd0);
    chk("arst_done", 80'(ap_done), 80'd0);
    chk("arst_idle", 80'(ap_idle), 80'd1);
    fifo_q.delete();
    exp_q.delete();
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    run_frame(tbl[0]);
    run_frame(tbl[6]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
